gpio_in_conditioner: RTL



---
 rtl/gpio_in_conditioner.sv | 88 ++++++++
 1 files changed

// File: rtl/gpio_in_conditioner.sv
// Purpose: synchronise, debounce and edge-detect raw board switch/button inputs for the SoC GPIO input bus.
// Latency: a new raw level held steady reaches stable_o DEBOUNCE_CYCLES+1 edges after it is first sampled.
// Backpressure: none; every input bit is conditioned independently each cycle and outputs are always valid.
module gpio_in_conditioner #(
    parameter int WIDTH           = 12,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic             clk_i,
    input  logic             srst_n_i,
    input  logic [WIDTH-1:0] raw_i,
    input  logic [WIDTH-1:0] clr_i,
    output logic [WIDTH-1:0] stable_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] event_o
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // s1 is the metastability-settling stage; only s2 is trusted downstream.
    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] event_q, event_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

    // Next-state: sync chain shift, per-bit debounce counters, edge pulses and sticky events.
    always_comb begin
        s1_d     = raw_i;
        s2_d     = s1_q;
        stable_d = stable_q;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] == stable_q[i]) begin
                // Matching the accepted level (or a glitch returning) restarts the count.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                // Level persisted long enough: accept it and pulse the matching edge.
                stable_d[i] = s2_q[i];
                rise_d[i]   = s2_q[i];
                fall_d[i]   = ~s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        // A rise on this edge wins over a simultaneous software clear.
        event_d = (event_q & ~clr_i) | rise_d;
    end

    // State registers; synchronous reset discards any partial debounce count.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            s1_q     <= '0;
            s2_q     <= '0;
            stable_q <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            event_q  <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            event_q  <= event_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign event_o  = event_q;

endmodule
